// File: rtl/id_imm_stage_if.sv
// Handshake and payload bundle between fetch, the decode immediate stage and execute.
// The stage connects through the slave modport; the fetch/execute side uses master.
interface id_imm_stage_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/id_imm_stage.sv
// Decode-stage front end: classifies the RV32I immediate format, assembles the
// sign-extended immediate and holds instr/PC/imm in one register toward execute.
module id_imm_stage #(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    id_imm_stage_if.slave          bus,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    logic                   r_valid;
    logic [31:0]            r_instr;
    logic [XLEN-1:0]        r_pc;
    logic [31:0]            r_imm;
    logic [2:0]             r_fmt;
    logic                   r_illegal;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic        w_in_ready;
    logic        w_accept;
    logic [2:0]  w_fmt;
    logic        w_illegal;
    logic [31:0] w_imm;

    assign w_in_ready = !flush_i && (!r_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Opcode to immediate-format classification
    always_comb begin
        w_fmt     = FMT_NONE;
        w_illegal = 1'b0;
        case (bus.in_instr[6:0])
            7'b0000011, 7'b0010011,
            7'b1100111, 7'b1110011: w_fmt = FMT_I;
            7'b0100011:             w_fmt = FMT_S;
            7'b1100011:             w_fmt = FMT_B;
            7'b0110111, 7'b0010111: w_fmt = FMT_U;
            7'b1101111:             w_fmt = FMT_J;
            7'b0110011:             w_fmt = FMT_R;
            default: begin
                w_fmt     = FMT_NONE;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Immediate assembly for the classified format
    always_comb begin
        w_imm = 32'h0000_0000;
        case (w_fmt)
            FMT_I:   w_imm = imm_i(bus.in_instr);
            FMT_S:   w_imm = imm_s(bus.in_instr);
            FMT_B:   w_imm = imm_b(bus.in_instr);
            FMT_U:   w_imm = imm_u(bus.in_instr);
            FMT_J:   w_imm = imm_j(bus.in_instr);
            default: w_imm = 32'h0000_0000;
        endcase
    end

    // Pipeline register: flush beats accept, accept beats drain, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_instr   <= 32'h0000_0000;
            r_pc      <= {XLEN{1'b0}};
            r_imm     <= 32'h0000_0000;
            r_fmt     <= FMT_NONE;
            r_illegal <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_instr   <= bus.in_instr;
            r_pc      <= bus.in_pc;
            r_imm     <= w_imm;
            r_fmt     <= w_fmt;
            r_illegal <= w_illegal;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Saturating backpressure counter; a flush cycle is not a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (!flush_i && r_valid && !bus.out_ready && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_valid;
    assign bus.out_instr   = r_instr;
    assign bus.out_pc      = r_pc;
    assign bus.out_imm     = r_imm;
    assign bus.out_fmt     = r_fmt;
    assign bus.out_illegal = r_illegal;
    assign stall_cnt       = r_stall_cnt;
endmodule

// File: doc/id_imm_stage.md
Name: id_imm_stage

Overview:
Decode-stage front end. It accepts fetched instructions over a valid/ready handshake, classifies the immediate format from the opcode, and assembles a 32-bit sign-extended immediate. The instruction, PC and immediate are held in one pipeline register toward execute. The registered immediate feeds the downstream 32→64 sign-extension unit. The block supports a pipeline flush, flags illegal opcodes, and keeps a saturating stall counter.

Parameters:
XLEN, 32, width of the PC path.
STALL_CNT_W, 16, width of the backpressure stall counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
flush_i  in  1  synchronous flush; invalidates the stage.
in_valid  in  1  fetch presents an instruction.
in_ready  out  1  stage can accept; combinational.
in_instr  in  32  raw instruction word.
in_pc  in  XLEN  PC of in_instr.
out_valid  out  1  registered entry valid.
out_ready  in  1  execute accepts the entry.
out_instr  out  32  registered instruction.
out_pc  out  XLEN  registered PC.
out_imm  out  32  registered immediate, sign-extended to 32 bits.
out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
out_illegal  out  1  opcode not in the supported RV32I set.
stall_cnt  out  STALL_CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (async, rst=1): out_valid=0; out_instr, out_pc, out_imm and stall_cnt=0; out_fmt=7; out_illegal=0. Outputs stay at these values while rst is held.
- in_ready = !flush_i && (!out_valid || out_ready). The path is combinational; no dependency on in_valid.
- Accept when in_valid && in_ready. On the next edge the register loads the instruction, PC, imm, fmt and illegal flag, and out_valid becomes 1. Latency is 1 cycle.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the register is replaced in the same edge. Full throughput is 1 instruction per cycle.
- Drain with no new input: out_valid falls to 0. Data registers may hold stale values.
- Hold (out_valid && !out_ready): all registered outputs stay stable, and stall_cnt increments. The counter saturates at all-ones and does not wrap. Only rst clears it.
- flush_i=1: out_valid becomes 0 on the next edge. in_ready is 0 during flush, so a concurrent in_valid is dropped and fetch must re-present the instruction. Flush has priority over accept and hold. stall_cnt does not increment in a flush cycle.
- Opcode decode, instr[6:0]:
  - 0000011, 0010011, 1100111, 1110011 → I-type.
  - 0100011 → S-type.
  - 1100011 → B-type.
  - 0110111, 0010111 → U-type.
  - 1101111 → J-type.
  - 0110011 → R-type.
  - Any other opcode → NONE with illegal=1.
- Immediate assembly; every format except R and NONE replicates instr[31] into the upper bits:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R or NONE: imm=0.
- Shift-immediates (OP-IMM with funct3 001/101) use the plain I-type rule; no special casing.
- An illegal entry still flows through the handshake normally, with out_illegal=1.
- Reset asserted mid-hold: the entry is discarded and out_valid=0 immediately.

Test Plan:
- Reset, then in_instr=0xFFF00093 (addi), in_pc=0x100, out_ready=1 → next cycle: out_valid=1, fmt=1, imm=0xFFFFFFFF, out_pc=0x100.
- Back-to-back with out_ready=1:
  - 0xFE112E23 (sw) → fmt=2, imm=0xFFFFFFFC.
  - 0xFE000CE3 (beq) → fmt=3, imm=0xFFFFFFF8.
  - 0x123452B7 (lui) → fmt=4, imm=0x12345000.
  - 0x001000EF (jal) → fmt=5, imm=0x00000800.
  - No bubbles; in_ready held at 1.
- Hold out_ready=0 for 5 cycles with an entry valid → outputs stable, in_ready=0, stall_cnt=5. Force the counter near all-ones and hold longer → it saturates at 0xFFFF.
- Assert flush_i with in_valid=1 and out_valid=1 → in_ready=0 that cycle; out_valid=0 next cycle; the input instruction does not appear at the output.
- in_instr=0x0000007F → out_illegal=1, fmt=7, imm=0. in_instr=0x002081B3 (add) → fmt=0, imm=0, illegal=0.
- Assert rst asynchronously between edges while holding → out_valid drops immediately; stall_cnt=0; fmt=7.
